// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product after WIDTH cycles.
// Define SEQ_MULTIPLIER_SIGNED_EN for two's-complement operands and product.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] r
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [PW-1:0]      mcand;
  logic [PW-1:0]      acc;
  logic [PW-1:0]      acc_sum;
  logic [PW-1:0]      product;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   cap_a;
  logic [WIDTH-1:0]   cap_b;
  logic               last;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic neg;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is exact unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] nv;
    nv = -v;
    return v[WIDTH-1] ? nv : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic s);
    logic signed [PW-1:0] ps;
    ps = signed'(p);
    return s ? -ps : ps;
  endfunction

  assign cap_a   = magnitude(a);
  assign cap_b   = magnitude(b);
  assign product = apply_sign(acc_sum, neg);
`else
  assign cap_a   = a;
  assign cap_b   = b;
  assign product = acc_sum;
`endif

  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign acc_sum = acc + (mplier[0] ? mcand : '0);
  assign busy    = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      r      <= '0;
      done   <= 1'b0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          mcand  <= {{WIDTH{1'b0}}, cap_a};
          mplier <= cap_b;
          acc    <= '0;
          cnt    <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
          neg    <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end
      end else begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        // Final partial product is folded straight into R on the completing edge.
        if (last) begin
          r    <= product;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
